// File: rtl/cnt_bcd_down_pkg.sv
// cnt_pkg: shared types and helpers for the BCD down-counter slice.
//   state_e   : controller states (IDLE, RUN)
//   BCD_W     : bits per BCD digit
//   BCD_MAX   : largest legal BCD digit value
//   bcd_clamp : saturates a 4-bit nibble to a legal BCD digit (0..9)
package cnt_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/cnt_bcd_down_if.sv
// cnt_bcd_down_if: control/data bundle for cnt_bcd_down.
//   EN, LOAD (active-low), START, STOP, DATA : driven by master
//   DOUT, BOUT, DONE, BUSY                   : driven by slave (the counter)
// DIGITS must match the counter's DIGITS parameter.
interface cnt_bcd_down_if #(
    parameter int DIGITS = 2
);
    logic                  EN;
    logic                  LOAD;
    logic                  START;
    logic                  STOP;
    logic [4*DIGITS-1:0]   DATA;
    logic [4*DIGITS-1:0]   DOUT;
    logic                  BOUT;
    logic                  DONE;
    logic                  BUSY;

    modport master (
        output EN, LOAD, START, STOP, DATA,
        input  DOUT, BOUT, DONE, BUSY
    );

    modport slave (
        input  EN, LOAD, START, STOP, DATA,
        output DOUT, BOUT, DONE, BUSY
    );
endinterface

// File: rtl/cnt_bcd_down_digit.sv
// bcd_digit_down: one BCD digit of the down-counter.
//   CLK, RSTN  : clock, async active-low reset (digit resets to 0)
//   load       : load clamped load_val this cycle (has priority over borrow_in)
//   load_val   : raw nibble to load; values >9 are clamped to 9
//   borrow_in  : decrement this digit
//   borrow_out : digit is 0 while decrementing, so it wraps to 9 and borrows
//   digit      : current digit value
//   is_zero    : digit == 0
module bcd_digit_down
    import cnt_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             borrow_in,
    output logic             borrow_out,
    output logic [BCD_W-1:0] digit,
    output logic             is_zero
);
    logic [BCD_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load)
            digit_d = bcd_clamp(load_val);
        else if (borrow_in)
            digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) digit_q <= '0;
        else       digit_q <= digit_d;
    end

    assign digit      = digit_q;
    assign is_zero    = (digit_q == '0);
    assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/cnt_bcd_down.sv
// cnt_bcd_down: multi-digit loadable BCD down-counter with IDLE/RUN control.
//   CLK, RSTN : clock (rising edge), async active-low reset
//   bus       : cnt_bcd_down_if.slave
//               EN tick, LOAD (active-low sync load), START, STOP, DATA preset,
//               DOUT count, BOUT (DOUT==0, combinational), DONE (1-cycle pulse
//               on reaching zero in RUN), BUSY (in RUN)
// Edge priority: STOP > LOAD > START > decrement.
// Optional: CNT_BCD_DOWN_AUTORELOAD_EN reloads the last loaded (clamped) preset
// instead of stopping at zero; a zero preset falls back to normal stop.
module cnt_bcd_down
    import cnt_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic           CLK,
    input  logic           RSTN,
    cnt_bcd_down_if.slave  bus
);
    localparam int CW = BCD_W * DIGITS;

    logic [CW-1:0]     data_clamp;
    logic [CW-1:0]     ld_val;
    logic [CW-1:0]     dout;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] dig_zero;
    logic              ld, dec, all_zero, is_one, reload_ok;
    logic              done_q, done_d;
    state_e            state_q, state_d, state_nxt;

    // Digit chain: borrow[0] is the decrement request, each digit passes a
    // borrow upward when it wraps 0 -> 9.
    assign borrow[0] = dec;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign data_clamp[i*BCD_W +: BCD_W] = bcd_clamp(bus.DATA[i*BCD_W +: BCD_W]);

        bcd_digit_down u_digit (
            .CLK        (CLK),
            .RSTN       (RSTN),
            .load       (ld),
            .load_val   (ld_val[i*BCD_W +: BCD_W]),
            .borrow_in  (borrow[i]),
            .borrow_out (borrow[i+1]),
            .digit      (dout[i*BCD_W +: BCD_W]),
            .is_zero    (dig_zero[i])
        );
    end

    assign all_zero = &dig_zero;
    assign is_one   = (dout == CW'(1));

`ifdef CNT_BCD_DOWN_AUTORELOAD_EN
    logic [CW-1:0] shadow_q, shadow_d;

    // A load with LOAD high can only be an auto-reload from the shadow.
    assign ld_val    = bus.LOAD ? shadow_q : bus.DATA;
    assign shadow_d  = (ld && !bus.LOAD) ? data_clamp : shadow_q;
    assign reload_ok = (shadow_q != '0);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end
`else
    assign ld_val    = bus.DATA;
    assign reload_ok = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        done_d    = 1'b0;
        ld        = 1'b0;
        dec       = 1'b0;
        if (bus.STOP) begin
            state_nxt = IDLE;
        end else if (!bus.LOAD) begin
            ld = 1'b1;
            // Loading zero while running is an abort, not a terminal count.
            if (state_q == RUN && data_clamp == '0)
                state_nxt = IDLE;
        end else if (bus.START && state_q == IDLE) begin
            if (!all_zero)
                state_nxt = RUN;
        end else if (state_q == RUN && bus.EN) begin
            if (is_one) begin
                done_d = 1'b1;
                if (reload_ok) begin
                    ld = 1'b1;
                end else begin
                    dec       = 1'b1;
                    state_nxt = IDLE;
                end
            end else begin
                dec = 1'b1;
            end
        end
    end

    // A borrow out of the top digit means we decremented from zero; that is
    // unreachable in RUN, but if it ever happens drop to IDLE rather than spin.
    assign state_d = borrow[DIGITS] ? IDLE : state_nxt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign bus.DOUT = dout;
    assign bus.BOUT = all_zero;
    assign bus.DONE = done_q;
    assign bus.BUSY = (state_q == RUN);

endmodule
